// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// Contents:
//   - default address/data widths and starvation-guard limit
//   - bus owner encoding (ARB / LOCKED)
//   - streak_w(): width of the starvation streak counter, never below one bit
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF     = 4;
  localparam int DATA_W_DEF     = 8;
  localparam int MAX_STREAK_DEF = 4;

  // Who may use the memory this cycle: normal arbitration, or debug holds it exclusively.
  typedef enum logic {
    OWN_ARB    = 1'b0,
    OWN_LOCKED = 1'b1
  } owner_e;

  // A guard limit of 0 still needs a one-bit counter so the instance stays legal.
  function automatic int streak_w(input int max_streak);
    if (max_streak > 0) begin
      return $clog2(max_streak + 1);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant and memory-side bus of the memory port arbiter.
// Modports:
//   master : requesters (core + debug port) and the memory macro; drives requests and mem_rdata
//   slave  : the arbiter; drives grants, stall, read-valid strobes and the muxed memory port
// Signals:
//   cpu_req/we/addr/wdata, cpu_gnt, cpu_rvalid, cpu_stall  - core port
//   dbg_req/we/lock/addr/wdata, dbg_gnt, dbg_rvalid         - debug/loader port
//   mem_en/we/addr/wdata, mem_rdata                         - memory macro port
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic              dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_stall,
    input  dbg_gnt, dbg_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  // mem_rdata goes straight from the macro to both requesters; the arbiter never looks at it.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output cpu_gnt, cpu_rvalid, cpu_stall,
    output dbg_gnt, dbg_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_streak_ctr.sv
// Saturating streak counter for the debug starvation guard.
// Ports:
//   clk    in  clock
//   rst    in  asynchronous active-high reset, clears the count
//   inc_i  in  count one more CPU win over a pending debug request
//   clr_i  in  restart the streak (wins over inc_i)
//   sat_o  out count has reached MAX
module mem_port_arbiter_streak_ctr #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear has priority, increment stops at MAX so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares the single-port memory between the core and the debug/loader port.
// The core has fixed priority; a streak counter hands the port to a waiting debug request after
// MAX_STREAK consecutive core wins (0 disables the guard). A debug access with dbg_lock=1 makes
// debug the exclusive owner until a debug access with dbg_lock=0 is granted.
// Ports:
//   clk    in  clock, all state on the rising edge
//   reset  in  asynchronous active-high reset
//   bus    slave modport of mem_port_arbiter_if (requests, grants, rvalid, muxed memory port)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_STREAK = MAX_STREAK_DEF
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int STREAK_W = streak_w(MAX_STREAK);
  localparam bit GUARD_EN = (MAX_STREAK > 0);

  owner_e            owner_q;
  logic              cpu_rvalid_q;
  logic              dbg_rvalid_q;
  logic              cpu_gnt;
  logic              dbg_gnt;
  logic              streak_sat;
  logic              mem_we_mux;
  logic [ADDR_W-1:0] mem_addr_mux;
  logic [DATA_W-1:0] mem_wdata_mux;

  // Grant decision. Grants are held low during reset so nothing reaches the memory.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (reset) begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end else begin
      case (owner_q)
        OWN_ARB: begin
          if (bus.cpu_req && bus.dbg_req) begin
            if (GUARD_EN && streak_sat) begin
              dbg_gnt = 1'b1;
            end else begin
              cpu_gnt = 1'b1;
            end
          end else begin
            cpu_gnt = bus.cpu_req;
            dbg_gnt = bus.dbg_req;
          end
        end
        OWN_LOCKED: begin
          cpu_gnt = 1'b0;
          dbg_gnt = bus.dbg_req;
        end
        default: begin
          cpu_gnt = 1'b0;
          dbg_gnt = 1'b0;
        end
      endcase
    end
  end

  // Memory port mux; idle cycles drive zeros rather than a stale requester's fields.
  always_comb begin
    mem_we_mux    = 1'b0;
    mem_addr_mux  = {ADDR_W{1'b0}};
    mem_wdata_mux = {DATA_W{1'b0}};
    if (cpu_gnt) begin
      mem_we_mux    = bus.cpu_we;
      mem_addr_mux  = bus.cpu_addr;
      mem_wdata_mux = bus.cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we_mux    = bus.dbg_we;
      mem_addr_mux  = bus.dbg_addr;
      mem_wdata_mux = bus.dbg_wdata;
    end else begin
      mem_we_mux    = 1'b0;
      mem_addr_mux  = {ADDR_W{1'b0}};
      mem_wdata_mux = {DATA_W{1'b0}};
    end
  end

  // Owner FSM plus read-valid strobes, which mark the cycle the macro's read data is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q      <= OWN_ARB;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_gnt & ~bus.cpu_we;
      dbg_rvalid_q <= dbg_gnt & ~bus.dbg_we;
      case (owner_q)
        OWN_ARB: begin
          if (dbg_gnt && bus.dbg_lock) begin
            owner_q <= OWN_LOCKED;
          end else begin
            owner_q <= OWN_ARB;
          end
        end
        OWN_LOCKED: begin
          // Debug keeps ownership even while dbg_req is low between locked accesses.
          if (dbg_gnt && !bus.dbg_lock) begin
            owner_q <= OWN_ARB;
          end else begin
            owner_q <= OWN_LOCKED;
          end
        end
        default: begin
          owner_q <= OWN_ARB;
        end
      endcase
    end
  end

  // The streak only counts while debug is actually waiting; a debug grant or an idle debug
  // port starts it over.
  mem_port_arbiter_streak_ctr #(
    .MAX (MAX_STREAK),
    .W   (STREAK_W)
  ) u_streak (
    .clk   (clk),
    .rst   (reset),
    .inc_i (cpu_gnt & bus.dbg_req),
    .clr_i (dbg_gnt | ~bus.dbg_req),
    .sat_o (streak_sat)
  );

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.mem_en     = cpu_gnt | dbg_gnt;
  assign bus.mem_we     = mem_we_mux;
  assign bus.mem_addr   = mem_addr_mux;
  assign bus.mem_wdata  = mem_wdata_mux;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level model (owner flag, integer streak, shadow memory).
module tb_mem_port_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus_b ();

  mem_port_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_STREAK(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  mem_port_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_STREAK(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] init_val(input int i);
    logic [3:0] a;
    a = 4'(i);
    return {a, ~a} ^ 8'h99;
  endfunction

  // Synchronous-read memory macros, reloaded with the init pattern while reset is high.
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_a[i] <= init_val(i);
      bus_a.mem_rdata <= 8'h00;
    end else if (bus_a.mem_en) begin
      if (bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
      else              bus_a.mem_rdata <= mem_a[bus_a.mem_addr];
    end
  end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_b[i] <= init_val(i);
      bus_b.mem_rdata <= 8'h00;
    end else if (bus_b.mem_en) begin
      if (bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
      else              bus_b.mem_rdata <= mem_b[bus_b.mem_addr];
    end
  end

  // ---------------- reference model (for dut_a, guard limit 4) ----------------
  localparam int MAXS = 4;
  bit         m_locked;
  int         m_streak;
  logic [7:0] m_mem [16];
  bit         e_cg, e_dg, e_crv, e_drv;
  logic [7:0] e_crd, e_drd;

  function automatic void grant_rule(input bit locked, input int streak, input int maxs,
                                     input bit cr, input bit dr, output bit cg, output bit dg);
    cg = 1'b0;
    dg = 1'b0;
    if (locked) dg = dr;
    else if (cr && dr) begin
      if (maxs > 0 && streak >= maxs) dg = 1'b1;
      else                            cg = 1'b1;
    end else begin
      cg = cr;
      dg = dr;
    end
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_streak = 0;
    e_crv    = 1'b0;
    e_drv    = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
  endtask

  // Apply the effect of one clock edge given the grants predicted for the cycle before it.
  task automatic model_edge();
    e_crv = e_cg && !bus_a.cpu_we;
    e_drv = e_dg && !bus_a.dbg_we;
    if (e_crv) e_crd = m_mem[bus_a.cpu_addr];
    if (e_drv) e_drd = m_mem[bus_a.dbg_addr];
    if (e_cg && bus_a.cpu_we) m_mem[bus_a.cpu_addr] = bus_a.cpu_wdata;
    if (e_dg && bus_a.dbg_we) m_mem[bus_a.dbg_addr] = bus_a.dbg_wdata;
    if (e_cg && bus_a.dbg_req) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
    if (e_dg || !bus_a.dbg_req) m_streak = 0;
    if (e_dg) m_locked = bus_a.dbg_lock;
  endtask

  // Inputs are driven at posedge+1; settle moves to posedge+4 and predicts the grants.
  task automatic settle();
    #3;
    grant_rule(m_locked, m_streak, MAXS, bus_a.cpu_req, bus_a.dbg_req, e_cg, e_dg);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_cpu(input bit req, input bit we, input logic [3:0] a, input logic [7:0] d);
    bus_a.cpu_req = req; bus_a.cpu_we = we; bus_a.cpu_addr = a; bus_a.cpu_wdata = d;
  endtask

  task automatic drive_dbg(input bit req, input bit we, input bit lk, input logic [3:0] a,
                           input logic [7:0] d);
    bus_a.dbg_req = req; bus_a.dbg_we = we; bus_a.dbg_lock = lk;
    bus_a.dbg_addr = a; bus_a.dbg_wdata = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_cpu(1'b1, 1'b1, 4'h2, 8'h5C);
    drive_dbg(1'b1, 1'b1, 1'b0, 4'h9, 8'hC3);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #4;
    checks++;
    if ({bus_a.cpu_gnt, bus_a.dbg_gnt, bus_a.cpu_rvalid, bus_a.dbg_rvalid,
         bus_a.mem_en, bus_a.mem_we} !== 6'b000000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000", {bus_a.cpu_gnt, bus_a.dbg_gnt,
               bus_a.cpu_rvalid, bus_a.dbg_rvalid, bus_a.mem_en, bus_a.mem_we});
    end
    checks++;
    if ({bus_a.mem_addr, bus_a.mem_wdata} !== 12'h000) begin
      failures++;
      $display("FAIL reset_mux got=%h exp=000", {bus_a.mem_addr, bus_a.mem_wdata});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    settle();
    checks++;
    if ({bus_a.cpu_gnt, bus_a.dbg_gnt} !== 2'b10 || {e_cg, e_dg} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release_gnt got=%b exp=10", {bus_a.cpu_gnt, bus_a.dbg_gnt});
    end
    advance();
    // CPU request done; debug is still waiting and gets the port now.
    drive_cpu(1'b0, 1'b0, 4'h0, 8'h00);
    settle();
    checks++;
    if ({bus_a.cpu_gnt, bus_a.dbg_gnt} !== {e_cg, e_dg}) begin
      failures++;
      $display("FAIL reset_dbg_follow got=%b exp=%b", {bus_a.cpu_gnt, bus_a.dbg_gnt}, {e_cg, e_dg});
    end
    advance();
    drive_dbg(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    settle();
    advance();
  endtask

  task automatic test_cpu_read();
    drive_cpu(1'b1, 1'b0, 4'h3, 8'h00);
    settle();
    checks++;
    if ({bus_a.cpu_gnt, bus_a.dbg_gnt, bus_a.cpu_stall, bus_a.mem_en, bus_a.mem_we,
         bus_a.mem_addr} !== {5'b10010, 4'h3}) begin
      failures++;
      $display("FAIL cpu_read_issue got=%b exp=%b", {bus_a.cpu_gnt, bus_a.dbg_gnt,
               bus_a.cpu_stall, bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr}, {5'b10010, 4'h3});
    end
    advance();
    drive_cpu(1'b0, 1'b0, 4'h0, 8'h00);
    settle();
    checks++;
    if ({bus_a.cpu_rvalid, bus_a.dbg_rvalid, bus_a.mem_rdata} !== {2'b10, 8'hA5}) begin
      failures++;
      $display("FAIL cpu_read_data got=%b/%b/%h exp=1/0/a5",
               bus_a.cpu_rvalid, bus_a.dbg_rvalid, bus_a.mem_rdata);
    end
    advance();
  endtask

  task automatic test_streak();
    logic [9:0] pat;
    pat = 10'b1000010000;
    drive_cpu(1'b1, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom));
    drive_dbg(1'b1, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 8'($urandom));
    for (int i = 0; i < 10; i++) begin
      settle();
      checks++;
      if ({bus_a.cpu_gnt, bus_a.dbg_gnt} !== {~pat[i], pat[i]} ||
          {bus_a.cpu_gnt, bus_a.dbg_gnt} !== {e_cg, e_dg}) begin
        failures++;
        $display("FAIL streak_pattern[%0d] got=%b exp=%b", i,
                 {bus_a.cpu_gnt, bus_a.dbg_gnt}, {~pat[i], pat[i]});
      end
      advance();
      if (e_cg) drive_cpu(1'b1, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom));
      if (e_dg) drive_dbg(1'b1, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 8'($urandom));
    end
    drive_cpu(1'b0, 1'b0, 4'h0, 8'h00);
    drive_dbg(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    settle();
    advance();
  endtask

  task automatic test_lock();
    bit got;
    logic [7:0] rb [3];
    rb  = '{8'h11, 8'h22, 8'h33};
    got = 1'b0;
    drive_cpu(1'b1, 1'b0, 4'h5, 8'h00);
    drive_dbg(1'b1, 1'b1, 1'b1, 4'h0, 8'h11);
    for (int k = 0; k < 8; k++) begin
      if (!got) begin
        settle();
        checks++;
        if ({bus_a.cpu_gnt, bus_a.dbg_gnt} !== {e_cg, e_dg}) begin
          failures++;
          $display("FAIL lock_wait_gnt[%0d] got=%b exp=%b", k,
                   {bus_a.cpu_gnt, bus_a.dbg_gnt}, {e_cg, e_dg});
        end
        if (bus_a.dbg_gnt === 1'b1) got = 1'b1;
        else advance();
      end
    end
    checks++;
    if (got !== 1'b1) begin
      failures++;
      $display("FAIL lock_first_grant got=timeout exp=dbg_gnt within 8 cycles");
    end else if (bus_a.cpu_stall !== 1'b1) begin
      failures++;
      $display("FAIL lock_stall_0 got=%b exp=1", bus_a.cpu_stall);
    end
    advance();
    for (int j = 0; j < 2; j++) begin
      drive_dbg(1'b1, 1'b1, (j == 0), 4'(j + 1), (j == 0) ? 8'h22 : 8'h33);
      settle();
      checks++;
      if ({bus_a.cpu_stall, bus_a.cpu_gnt, bus_a.dbg_gnt} !== 3'b101) begin
        failures++;
        $display("FAIL lock_stall_%0d got=%b exp=101", j + 1,
                 {bus_a.cpu_stall, bus_a.cpu_gnt, bus_a.dbg_gnt});
      end
      advance();
    end
    drive_dbg(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    settle();
    checks++;
    if ({bus_a.cpu_stall, bus_a.cpu_gnt} !== 2'b01) begin
      failures++;
      $display("FAIL lock_release_cpu got=%b exp=01", {bus_a.cpu_stall, bus_a.cpu_gnt});
    end
    advance();
    drive_cpu(1'b0, 1'b0, 4'h0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive_dbg(1'b1, 1'b0, 1'b0, 4'(i), 8'h00);
      else       drive_dbg(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
      settle();
      if (i > 0) begin
        checks++;
        if (bus_a.dbg_rvalid !== 1'b1 || bus_a.mem_rdata !== rb[i-1]) begin
          failures++;
          $display("FAIL lock_readback[%0d] got=%b/%h exp=1/%h", i - 1,
                   bus_a.dbg_rvalid, bus_a.mem_rdata, rb[i-1]);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_locked();
    drive_cpu(1'b0, 1'b0, 4'h0, 8'h00);
    drive_dbg(1'b1, 1'b1, 1'b1, 4'h9, 8'h77);
    settle();
    advance();
    drive_dbg(1'b1, 1'b0, 1'b1, 4'h7, 8'h00);
    settle();
    checks++;
    if (bus_a.dbg_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rstlock_read_gnt got=%b exp=1", bus_a.dbg_gnt);
    end
    advance();
    drive_dbg(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    checks++;
    if (bus_a.dbg_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL rstlock_pending got=%b exp=1", bus_a.dbg_rvalid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus_a.dbg_rvalid, bus_a.cpu_rvalid, bus_a.dbg_gnt} !== 3'b000) begin
      failures++;
      $display("FAIL rstlock_drop got=%b exp=000",
               {bus_a.dbg_rvalid, bus_a.cpu_rvalid, bus_a.dbg_gnt});
    end
    model_reset();
    @(posedge clk);
    #1;
    drive_cpu(1'b1, 1'b0, 4'h1, 8'h00);
    drive_dbg(1'b1, 1'b0, 1'b0, 4'h2, 8'h00);
    reset = 1'b0;
    settle();
    checks++;
    if ({bus_a.cpu_gnt, bus_a.dbg_gnt} !== 2'b10 || {e_cg, e_dg} !== 2'b10) begin
      failures++;
      $display("FAIL rstlock_cpu_first got=%b exp=10", {bus_a.cpu_gnt, bus_a.dbg_gnt});
    end
    advance();
    drive_cpu(1'b0, 1'b0, 4'h0, 8'h00);
    settle();
    checks++;
    if ({bus_a.dbg_gnt, bus_a.cpu_rvalid, bus_a.mem_rdata} !== {2'b11, e_crd}) begin
      failures++;
      $display("FAIL rstlock_after got=%b/%b/%h exp=1/1/%h",
               bus_a.dbg_gnt, bus_a.cpu_rvalid, bus_a.mem_rdata, e_crd);
    end
    advance();
    drive_dbg(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    settle();
    advance();
  endtask

  task automatic test_random();
    bit c_act, d_act;
    logic [13:0] exp_mux;
    c_act = 1'b0;
    d_act = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!c_act && $urandom_range(0, 99) < 60) begin
        c_act = 1'b1;
        drive_cpu(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
      end else if (!c_act) begin
        drive_cpu(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
      end
      if (!d_act && $urandom_range(0, 99) < 60) begin
        d_act = 1'b1;
        drive_dbg(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 30),
                  4'($urandom_range(0, 15)), 8'($urandom));
      end else if (!d_act) begin
        drive_dbg(1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)), 8'($urandom));
      end
      settle();
      if (e_cg)      exp_mux = {1'b1, bus_a.cpu_we, bus_a.cpu_addr, bus_a.cpu_wdata};
      else if (e_dg) exp_mux = {1'b1, bus_a.dbg_we, bus_a.dbg_addr, bus_a.dbg_wdata};
      else           exp_mux = 14'h0000;
      checks++;
      if ({bus_a.cpu_gnt, bus_a.dbg_gnt, bus_a.cpu_stall} !==
          {e_cg, e_dg, bus_a.cpu_req & ~e_cg}) begin
        failures++;
        $display("FAIL rand_gnt[%0d] got=%b exp=%b", n,
                 {bus_a.cpu_gnt, bus_a.dbg_gnt, bus_a.cpu_stall},
                 {e_cg, e_dg, bus_a.cpu_req & ~e_cg});
      end
      checks++;
      if ({bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata} !== exp_mux) begin
        failures++;
        $display("FAIL rand_mux[%0d] got=%h exp=%h", n,
                 {bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata}, exp_mux);
      end
      checks++;
      if ({bus_a.cpu_rvalid, bus_a.dbg_rvalid} !== {e_crv, e_drv} ||
          (e_crv && bus_a.mem_rdata !== e_crd) || (e_drv && bus_a.mem_rdata !== e_drd)) begin
        failures++;
        $display("FAIL rand_rdata[%0d] got=%b%b/%h exp=%b%b/%h", n, bus_a.cpu_rvalid,
                 bus_a.dbg_rvalid, bus_a.mem_rdata, e_crv, e_drv, e_crv ? e_crd : e_drd);
      end
      advance();
      if (e_cg) c_act = 1'b0;
      if (e_dg) d_act = 1'b0;
    end
    drive_cpu(1'b0, 1'b0, 4'h0, 8'h00);
    drive_dbg(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    settle();
    advance();
  endtask

  task automatic test_no_guard();
    bit cg, dg;
    bus_b.cpu_req = 1'b1; bus_b.cpu_we = 1'b0; bus_b.cpu_wdata = 8'h00;
    bus_b.dbg_req = 1'b1; bus_b.dbg_we = 1'b0; bus_b.dbg_lock = 1'b0;
    bus_b.dbg_addr = 4'hE; bus_b.dbg_wdata = 8'h00;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) bus_b.cpu_req = 1'b0;
      bus_b.cpu_addr = 4'($urandom_range(0, 15));
      #3;
      grant_rule(1'b0, i, 0, bus_b.cpu_req, bus_b.dbg_req, cg, dg);
      checks++;
      if ({bus_b.cpu_gnt, bus_b.dbg_gnt} !== {cg, dg} ||
          {bus_b.cpu_gnt, bus_b.dbg_gnt} !== ((i < 8) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL noguard[%0d] got=%b exp=%b", i, {bus_b.cpu_gnt, bus_b.dbg_gnt},
                 (i < 8) ? 2'b10 : 2'b01);
      end
      @(posedge clk);
      #1;
    end
    bus_b.dbg_req = 1'b0;
    #3;
    checks++;
    if ({bus_b.dbg_rvalid, bus_b.mem_rdata} !== {1'b1, init_val(14)}) begin
      failures++;
      $display("FAIL noguard_rdata got=%b/%h exp=1/%h", bus_b.dbg_rvalid, bus_b.mem_rdata,
               init_val(14));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_b.cpu_req = 1'b0; bus_b.cpu_we = 1'b0; bus_b.cpu_addr = 4'h0; bus_b.cpu_wdata = 8'h00;
    bus_b.dbg_req = 1'b0; bus_b.dbg_we = 1'b0; bus_b.dbg_lock = 1'b0;
    bus_b.dbg_addr = 4'h0; bus_b.dbg_wdata = 8'h00;
    test_reset();
    test_cpu_read();
    test_streak();
    test_lock();
    test_reset_locked();
    test_random();
    test_no_guard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=bench completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
